// File: rtl/csa_bist_pkg.sv
// Shared types and helpers for the carry-select adder BIST controller:
// FSM states, golden csc responses and the fault-map to repair lookup.
package csa_bist_pkg;

  localparam int CSC_OUT_W = 6;
  localparam int N_CSC     = 4;
  localparam int PAT_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_CHECK,
    ST_RESOLVE,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [2:0] is_v;
    logic [3:0] ss_v;
    logic       uncorrect;
  } repair_t;

  // Pattern is {a1,b1,a0,b0}; response is {c_ci1,c_ci0,s1_ci1,s1_ci0,s0_ci1,s0_ci0}.
  function automatic logic [CSC_OUT_W-1:0] csc_golden(input logic [PAT_W-1:0] pat);
    logic [2:0] sum_ci0;
    logic [2:0] sum_ci1;
    sum_ci0 = {1'b0, pat[3], pat[1]} + {1'b0, pat[2], pat[0]};
    sum_ci1 = sum_ci0 + 3'd1;
    return {sum_ci1[2], sum_ci0[2], sum_ci1[1], sum_ci0[1], sum_ci1[0], sum_ci0[0]};
  endfunction

  function automatic repair_t repair_lookup(input logic [N_CSC-1:0] fault_map);
    repair_t r;
    r = '{is_v: 3'b000, ss_v: 4'b0000, uncorrect: 1'b0};
    case (fault_map)
      4'b0000: r = '{is_v: 3'b000, ss_v: 4'b0000, uncorrect: 1'b0};
      4'b0001: r = '{is_v: 3'b111, ss_v: 4'b1111, uncorrect: 1'b0};
      4'b0010: r = '{is_v: 3'b110, ss_v: 4'b1110, uncorrect: 1'b0};
      4'b0100: r = '{is_v: 3'b100, ss_v: 4'b1100, uncorrect: 1'b0};
      4'b1000: r = '{is_v: 3'b000, ss_v: 4'b1000, uncorrect: 1'b0};
      default: r = '{is_v: 3'b000, ss_v: 4'b0000, uncorrect: 1'b1};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/csa_bist_checker.sv
// Combinational compare of the 24-bit adder test response against the
// golden response of the applied pattern; one mismatch bit per csc.
module csa_bist_checker
  import csa_bist_pkg::*;
(
  input  logic [N_CSC*CSC_OUT_W-1:0] i_test_output,
  input  logic [PAT_W-1:0]           i_pat,
  output logic [N_CSC-1:0]           o_mismatch
);

  logic [CSC_OUT_W-1:0] w_gold;

  always_comb begin
    o_mismatch = '0;
    w_gold     = csc_golden(i_pat);
    for (int k = 0; k < N_CSC; k++) begin
      o_mismatch[k] = (i_test_output[k*CSC_OUT_W +: CSC_OUT_W] != w_gold);
    end
  end

endmodule

// File: rtl/csa_bist_controller.sv
// BIST initiator for the carry-select adder: sweeps all csc patterns,
// builds the per-csc fault map and derives the spare-steering vectors.
module csa_bist_controller
  import csa_bist_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_start,
  input  logic [N_CSC*CSC_OUT_W-1:0] i_test_output,
  output logic                       o_test,
  output logic [PAT_W-1:0]           o_test_data,
  output logic [2:0]                 o_is,
  output logic [3:0]                 o_ss,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [N_CSC-1:0]           o_fault_map,
  output logic                       o_uncorrect,
  output logic [PAT_W-1:0]           o_first_fail
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t           r_state;
  state_t           w_next;
  logic [PAT_W-1:0] r_pat;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [N_CSC-1:0] r_fault_map;
  logic [PAT_W-1:0] r_first_fail;
  logic             r_any_fail;
  logic [2:0]       r_is;
  logic [3:0]       r_ss;
  logic             r_uncorrect;
  logic [N_CSC-1:0] w_mismatch;
  repair_t          w_repair;

  csa_bist_checker u_checker (
    .i_test_output (i_test_output),
    .i_pat         (r_pat),
    .o_mismatch    (w_mismatch)
  );

  assign w_repair = repair_lookup(r_fault_map);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (i_start) w_next = ST_APPLY;
      ST_APPLY:   w_next = ST_WAIT;
      ST_WAIT:    if (r_cnt == '0) w_next = ST_CHECK;
      ST_CHECK:   w_next = (r_pat == '1) ? ST_RESOLVE : ST_APPLY;
      ST_RESOLVE: w_next = ST_DONE;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat        <= '0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fault_map  <= '0;
      r_first_fail <= '0;
      r_any_fail   <= 1'b0;
      r_is         <= '0;
      r_ss         <= '0;
      r_uncorrect  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_fault_map  <= '0;
            r_first_fail <= '0;
            r_uncorrect  <= 1'b0;
            r_any_fail   <= 1'b0;
            r_pat        <= '0;
            r_busy       <= 1'b1;
          end
        end
        ST_APPLY: r_cnt <= CW'(SETTLE - 1);
        ST_WAIT:  if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        ST_CHECK: begin
          r_fault_map <= r_fault_map | w_mismatch;
          if (!r_any_fail && (|w_mismatch)) begin
            r_first_fail <= r_pat;
            r_any_fail   <= 1'b1;
          end
          if (r_pat != '1) r_pat <= r_pat + PAT_W'(1);
        end
        ST_RESOLVE: begin
          r_is        <= w_repair.is_v;
          r_ss        <= w_repair.ss_v;
          r_uncorrect <= w_repair.uncorrect;
        end
        // done and busy change together on the edge leaving DONE
        ST_DONE: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_test       = (r_state == ST_APPLY) || (r_state == ST_WAIT) || (r_state == ST_CHECK);
  assign o_test_data  = r_pat;
  assign o_is         = r_is;
  assign o_ss         = r_ss;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_fault_map  = r_fault_map;
  assign o_uncorrect  = r_uncorrect;
  assign o_first_fail = r_first_fail;

endmodule

// File: tb/tb_csa_bist_controller.sv
// Bench for csa_bist_controller: a behavioural adder with injectable stuck
// bits and an arithmetic reference model for fault map, repair and latency.
module tb_csa_bist_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] test_output;
  logic        test;
  logic [3:0]  test_data;
  logic [2:0]  is_v;
  logic [3:0]  ss_v;
  logic        busy;
  logic        done;
  logic [3:0]  fault_map;
  logic        uncorrect;
  logic [3:0]  first_fail;

  logic [23:0] stuck_mask = '0;
  logic [23:0] stuck_val  = '0;
  logic [23:0] gold24;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  csa_bist_controller #(.SETTLE(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (start),
    .i_test_output (test_output),
    .o_test        (test),
    .o_test_data   (test_data),
    .o_is          (is_v),
    .o_ss          (ss_v),
    .o_busy        (busy),
    .o_done        (done),
    .o_fault_map   (fault_map),
    .o_uncorrect   (uncorrect),
    .o_first_fail  (first_fail)
  );

  // Arithmetic csc response: two 2-bit adds with carry-in 0 and 1.
  function automatic logic [5:0] ref_csc(input int p);
    int a, b, s0, s1;
    a  = 2 * ((p / 8) % 2) + ((p / 2) % 2);
    b  = 2 * ((p / 4) % 2) + (p % 2);
    s0 = a + b;
    s1 = a + b + 1;
    return {s1[2], s0[2], s1[1], s0[1], s1[0], s0[0]};
  endfunction

  assign gold24      = {4{ref_csc(int'(test_data))}};
  assign test_output = test ? ((gold24 & ~stuck_mask) | (stuck_val & stuck_mask)) : 24'h0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_faults();
    stuck_mask = '0;
    stuck_val  = '0;
  endtask

  task automatic stick(input int k, input int b, input bit v);
    stuck_mask[6*k + b] = 1'b1;
    stuck_val[6*k + b]  = v;
  endtask

  task automatic expected(output logic [3:0] fm, output logic [3:0] ff, output logic unc,
                          output logic [2:0] ev_is, output logic [3:0] ev_ss);
    logic [23:0] g, r;
    bit found;
    int nf;
    fm = '0; ff = '0; found = 0; nf = 0;
    for (int p = 0; p < 16; p++) begin
      g = {4{ref_csc(p)}};
      r = (g & ~stuck_mask) | (stuck_val & stuck_mask);
      for (int k = 0; k < 4; k++) begin
        if (r[6*k +: 6] != g[6*k +: 6]) begin
          fm[k] = 1'b1;
          if (!found) begin
            ff = 4'(p);
            found = 1;
          end
        end
      end
    end
    for (int k = 0; k < 4; k++) nf += int'(fm[k]);
    unc = (nf > 1);
    ev_is = 3'b000; ev_ss = 4'b0000;
    if (nf == 1) begin
      if (fm[0])      begin ev_is = 3'b111; ev_ss = 4'b1111; end
      else if (fm[1]) begin ev_is = 3'b110; ev_ss = 4'b1110; end
      else if (fm[2]) begin ev_is = 3'b100; ev_ss = 4'b1100; end
      else            begin ev_is = 3'b000; ev_ss = 4'b1000; end
    end
  endtask

  task automatic run_sweep(input string tag, input bit repulse);
    logic [3:0] efm, eff;
    logic       eunc;
    logic [2:0] eis;
    logic [3:0] ess;
    int cyc, got;
    expected(efm, eff, eunc, eis, ess);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    got = -1;
    check_val({tag, "/busy_on"}, 32'(busy), 32'd1);
    check_val({tag, "/test_on"}, 32'(test), 32'd1);
    check_val({tag, "/res_clr"}, {27'd0, fault_map, uncorrect}, 32'd0);
    while (got < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = repulse && (cyc == 10);
      if (done) got = cyc;
    end
    start = 1'b0;
    check_val({tag, "/latency"}, 32'(got), 32'd50);
    check_val({tag, "/busy_off"}, {30'd0, busy, test}, 32'd0);
    check_val({tag, "/fault_map"}, 32'(fault_map), 32'(efm));
    check_val({tag, "/first_fail"}, 32'(first_fail), 32'(eff));
    check_val({tag, "/uncorrect"}, 32'(uncorrect), 32'(eunc));
    check_val({tag, "/is_ss"}, {25'd0, is_v, ss_v}, {25'd0, eis, ess});
    @(negedge clk);
    check_val({tag, "/done_pulse"}, 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check_val({tag, "/hold"}, {20'd0, fault_map, first_fail, is_v, uncorrect},
              {20'd0, efm, eff, eis, eunc});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_val("reset_in", {14'd0, test, test_data, is_v, ss_v, busy, done, fault_map, uncorrect, first_fail}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_val("reset_out", {14'd0, test, test_data, is_v, ss_v, busy, done, fault_map, uncorrect, first_fail}, 32'd0);

    clear_faults();
    for (int b = 0; b < 6; b++) stick(1, b, 1'b0);
    run_sweep("csc1_zero", 1'b0);
    check_val("csc1_zero/const", {20'd0, fault_map, is_v, ss_v, first_fail[0]}, {20'd0, 4'b0010, 3'b110, 4'b1110, 1'b0});

    clear_faults();
    run_sweep("clean", 1'b0);

    clear_faults();
    stick(0, 3, 1'b1);
    stick(3, 0, 1'b0);
    run_sweep("csc0_csc3", 1'b0);

    clear_faults();
    stick(2, 1, 1'b0);
    run_sweep("csc2_s0ci1_repulse", 1'b1);

    // Abort a sweep with reset at cycle 20 after a faulty run left results set.
    clear_faults();
    stick(3, 5, 1'b1);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("mid_reset", {14'd0, test, test_data, is_v, ss_v, busy, done, fault_map, uncorrect, first_fail}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_sweep("after_reset", 1'b0);

    for (int it = 0; it < 6; it++) begin
      int nf;
      clear_faults();
      nf = $urandom_range(0, 2);
      for (int j = 0; j < nf; j++)
        stick($urandom_range(0, 3), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
      run_sweep($sformatf("rand%0d", it), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
